atd_block_tracker: RTL and testbench
====================================

# atd_block_tracker

Parametrised successor to the single-channel ATD data-ready detector. Counts bits shifted in from the ATD deserialiser and credits the consumer with one ready unit per completed block, or per chunk once the first block has filled (stream mode). Keeps a saturating credit count with a take handshake and sticky error flags, and drives the `data_ready` strobe seen by the downstream FIFO/encryption logic.

## Interface

Parameters:
- `BLOCK_BITS`, 128: bits per block; power of two, ≥ 2·`CHUNK_BITS`.
- `CHUNK_BITS`, 16: bits per chunk; power of two, divides `BLOCK_BITS`.
- `MAX_PENDING`, 4: credit saturation limit, ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `shift_enable`  in  1  one ATD bit accepted this cycle.
- `data_taken`  in  1  consumer removes one credit this cycle.
- `flush`  in  1  synchronous clear of count, credits, primed, state.
- `stream_mode`  in  1  1 = chunk credits after priming; 0 = block credits only.
- `data_ready`  out  1  registered; pending ≠ 0.
- `pending`  out  `$clog2(MAX_PENDING+1)`  outstanding credits.
- `bit_count`  out  `$clog2(BLOCK_BITS)`  bit position in current block.
- `primed`  out  1  first full block seen since reset/flush.
- `block_done`  out  1  one-cycle pulse per completed block.
- `overflow`  out  1  sticky; credit event lost at saturation.
- `underflow`  out  1  sticky; take with pending = 0.

## Operation

- FSM states: IDLE (`bit_count` = 0, nothing received), FILL (accumulating first block, not primed), STREAM (primed).
- IDLE → FILL on first `shift_enable`; `stream_mode` is latched at that edge and ignored until the next IDLE.
- FILL → STREAM on block completion. STREAM persists until `flush` or `rst`, which go to IDLE.
- `bit_count` increments on `shift_enable` and wraps from `BLOCK_BITS-1` to 0.
- Block event: `shift_enable` while `bit_count` = `BLOCK_BITS-1`.
- Chunk event: `shift_enable` while `bit_count % CHUNK_BITS` = `CHUNK_BITS-1`.
- Credit generation, at most one per cycle:
  - Block mode: block events only.
  - Stream mode, FILL: block event only. Chunk events inside the first block give no credit.
  - Stream mode, STREAM: every chunk event. A block event is also a chunk event and is not double-counted.
- Credit update, net of generation and take:
  - Credit and take in the same cycle: `pending` unchanged.
  - Credit alone: `pending`+1, saturating at `MAX_PENDING`. A credit arriving at saturation sets `overflow`.
  - Take alone: `pending`−1. A take at 0 sets `underflow`; `pending` stays 0.
- `flush` has priority over `shift_enable` and `data_taken` in the same cycle. It clears `bit_count`, `pending`, `primed`, both sticky flags and `block_done`.
- `rst` has priority over everything.

## Timing

- All outputs are registered. Reset value of every output is 0, state IDLE.
- Credit latency: `pending`, `data_ready` and `block_done` update on the edge that samples the event; visible the cycle after the qualifying `shift_enable`.
- `data_taken` takes effect on the same edge; `data_ready` drops the next cycle if `pending` reaches 0.
- `primed` rises together with the first `block_done`.
- `shift_enable` or `data_taken` during `rst` or `flush` is discarded.
- Widths: `bit_count` arithmetic is modulo `BLOCK_BITS` with no extra bit. `pending` never exceeds `MAX_PENDING`.

## Structure

- Package `atd_tracker_pkg`: state enum (IDLE, FILL, STREAM) and mode constants (`MODE_BLOCK`, `MODE_STREAM`).
- One sub-module, `atd_bit_counter`: parametrised wrap counter with enable and synchronous clear. Outputs the count plus `chunk_evt` and `block_evt` combinational strobes.
- The top level holds the FSM, credit counter and flags.

## Test plan

Defaults are 128/16/4.
- Block mode, 128 `shift_enable` pulses, no take → one cycle after the 128th: `block_done` = 1 for one cycle, `pending` = 1, `data_ready` = 1, `primed` = 1. One `data_taken` → `pending` = 0, `data_ready` = 0.
- Stream mode, 128 pulses → `pending` = 1. Bits 16–112 of the first block give no credit. 16 more pulses → `pending` = 2. 32 more → `pending` = 4.
- Stream mode, no takes, 192 pulses → `pending` saturates at 4 on bit 176. Bit 192 sets `overflow`; `pending` stays 4. `overflow` holds until `flush`.
- Simultaneity and underflow:
  - `pending` = 2, chunk event and `data_taken` in the same cycle → `pending` = 2.
  - `data_taken` at `pending` = 0 → `underflow` = 1, `pending` = 0.
- Flush, stream mode: `flush` at `bit_count` = 70, with `shift_enable` high in that cycle → next cycle `bit_count` = 0, `primed` = 0, IDLE. A new credit needs a full 128 bits.
- Synchronous reset mid-STREAM with `pending` = 3: `rst` high for one edge with `shift_enable` = 1 → all outputs 0, the bit is not counted, `stream_mode` is relatched on the next first bit.

Source files
------------

// File: rtl/atd_tracker_pkg.sv
// Shared types for the ATD block tracker: FSM states and credit-mode encoding.
package atd_tracker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StStream
  } state_e;

  localparam logic MODE_BLOCK  = 1'b0;
  localparam logic MODE_STREAM = 1'b1;

endpackage

// File: rtl/atd_block_tracker_if.sv
// Handshake/status bundle between the ATD deserialiser side and the block tracker.
interface atd_block_tracker_if #(
  parameter int unsigned BLOCK_BITS  = 128,
  parameter int unsigned MAX_PENDING = 4
);
  localparam int unsigned CntW  = $clog2(BLOCK_BITS);
  localparam int unsigned PendW = $clog2(MAX_PENDING + 1);

  logic             shift_enable;
  logic             data_taken;
  logic             flush;
  logic             stream_mode;
  logic             data_ready;
  logic [PendW-1:0] pending;
  logic [CntW-1:0]  bit_count;
  logic             primed;
  logic             block_done;
  logic             overflow;
  logic             underflow;

  modport master (
    output shift_enable, data_taken, flush, stream_mode,
    input  data_ready, pending, bit_count, primed, block_done, overflow, underflow
  );

  modport slave (
    input  shift_enable, data_taken, flush, stream_mode,
    output data_ready, pending, bit_count, primed, block_done, overflow, underflow
  );
endinterface

// File: rtl/atd_bit_counter.sv
// Modulo-BLOCK_BITS bit counter with chunk/block completion strobes for the current bit.
module atd_bit_counter #(
  parameter int unsigned BLOCK_BITS = 128,
  parameter int unsigned CHUNK_BITS = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_en,
  input  logic                          i_clr,
  output logic [$clog2(BLOCK_BITS)-1:0] o_count,
  output logic                          o_chunk_evt,
  output logic                          o_block_evt
);
  localparam int unsigned CntW = $clog2(BLOCK_BITS);
  localparam logic [CntW-1:0] ChunkMask = CntW'(CHUNK_BITS - 1);
  localparam logic [CntW-1:0] BlockLast = CntW'(BLOCK_BITS - 1);

  logic [CntW-1:0] r_count;

  // Power-of-two block size: the natural wrap of r_count is the block boundary.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count     = r_count;
  assign o_chunk_evt = i_en && ((r_count & ChunkMask) == ChunkMask);
  assign o_block_evt = i_en && (r_count == BlockLast);

endmodule

// File: rtl/atd_block_tracker.sv
// ATD block tracker: FSM, saturating credit counter with take handshake, sticky error flags.
module atd_block_tracker
  import atd_tracker_pkg::*;
#(
  parameter int unsigned BLOCK_BITS  = 128,
  parameter int unsigned CHUNK_BITS  = 16,
  parameter int unsigned MAX_PENDING = 4
) (
  input logic                clk,
  input logic                rst,
  atd_block_tracker_if.slave bus
);
  localparam int unsigned PendW = $clog2(MAX_PENDING + 1);
  localparam logic [PendW-1:0] PendMax = PendW'(MAX_PENDING);

  state_e           r_state, w_state_nxt;
  logic             r_mode, w_mode_nxt;
  logic [PendW-1:0] r_pending, w_pend_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_unf, w_unf_nxt;
  logic             r_ready, r_primed, r_block_done;

  logic w_en, w_take, w_credit, w_chunk_evt, w_block_evt;

  // Flush discards any bit or take arriving in the same cycle.
  assign w_en   = bus.shift_enable && !bus.flush;
  assign w_take = bus.data_taken && !bus.flush;

  atd_bit_counter #(
    .BLOCK_BITS(BLOCK_BITS),
    .CHUNK_BITS(CHUNK_BITS)
  ) u_bit_counter (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_en),
    .i_clr      (bus.flush),
    .o_count    (bus.bit_count),
    .o_chunk_evt(w_chunk_evt),
    .o_block_evt(w_block_evt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    unique case (r_state)
      StIdle: begin
        if (w_en) begin
          w_state_nxt = StFill;
          w_mode_nxt  = bus.stream_mode;
        end
      end
      StFill:   if (w_block_evt) w_state_nxt = StStream;
      StStream: w_state_nxt = StStream;
      default:  w_state_nxt = StIdle;
    endcase
    if (bus.flush) w_state_nxt = StIdle;
  end

  // A block event is also a chunk event, so one strobe covers both in streaming.
  assign w_credit = (r_state == StStream && r_mode == MODE_STREAM) ? w_chunk_evt : w_block_evt;

  always_comb begin
    w_pend_nxt = r_pending;
    w_ovf_nxt  = r_ovf;
    w_unf_nxt  = r_unf;
    if (w_credit && !w_take) begin
      if (r_pending == PendMax) w_ovf_nxt = 1'b1;
      else                      w_pend_nxt = r_pending + 1'b1;
    end else if (w_take && !w_credit) begin
      if (r_pending == '0) w_unf_nxt = 1'b1;
      else                 w_pend_nxt = r_pending - 1'b1;
    end
    if (bus.flush) begin
      w_pend_nxt = '0;
      w_ovf_nxt  = 1'b0;
      w_unf_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_mode       <= MODE_BLOCK;
      r_pending    <= '0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
      r_ready      <= 1'b0;
      r_primed     <= 1'b0;
      r_block_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mode       <= w_mode_nxt;
      r_pending    <= w_pend_nxt;
      r_ovf        <= w_ovf_nxt;
      r_unf        <= w_unf_nxt;
      r_ready      <= (w_pend_nxt != '0);
      r_primed     <= (w_state_nxt == StStream);
      r_block_done <= w_block_evt;
    end
  end

  assign bus.data_ready = r_ready;
  assign bus.pending    = r_pending;
  assign bus.primed     = r_primed;
  assign bus.block_done = r_block_done;
  assign bus.overflow   = r_ovf;
  assign bus.underflow  = r_unf;

endmodule

// File: tb/tb_atd_block_tracker.sv
// Self-checking bench for atd_block_tracker: vector table, corner sequences, random vs model.
module tb_atd_block_tracker;
  localparam int BB = 128;
  localparam int CB = 16;
  localparam int MP = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  atd_block_tracker_if #(.BLOCK_BITS(BB), .MAX_PENDING(MP)) bus ();

  atd_block_tracker #(
    .BLOCK_BITS (BB),
    .CHUNK_BITS (CB),
    .MAX_PENDING(MP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  // Reference model: bits since the tracker left idle, credits, flags.
  int m_pos = 0, m_pending = 0;
  int m_active = 0, m_mode = 0, m_primed = 0, m_ovf = 0, m_unf = 0, m_bd = 0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(int se, int dt, int fl, int sm, int rs);
    int credit, blk, ce;
    if (rs != 0 || fl != 0) begin
      m_pos = 0; m_pending = 0; m_active = 0; m_mode = 0;
      m_primed = 0; m_ovf = 0; m_unf = 0; m_bd = 0;
    end else begin
      credit = 0;
      m_bd = 0;
      if (se != 0) begin
        if (m_active == 0) begin
          m_active = 1;
          m_mode = (sm != 0) ? 1 : 0;
        end
        blk = (((m_pos + 1) % BB) == 0) ? 1 : 0;
        ce  = (((m_pos + 1) % CB) == 0) ? 1 : 0;
        credit = (m_mode == 1 && m_primed == 1) ? ce : blk;
        m_bd = blk;
        if (blk == 1) m_primed = 1;
        m_pos = (m_pos + 1) % BB;
      end
      if (credit == 1 && dt == 0) begin
        if (m_pending == MP) m_ovf = 1;
        else m_pending++;
      end else if (credit == 0 && dt != 0) begin
        if (m_pending == 0) m_unf = 1;
        else m_pending--;
      end
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, "_bit_count"}, int'(bus.bit_count), m_pos);
    chk({tag, "_pending"}, int'(bus.pending), m_pending);
    chk({tag, "_data_ready"}, int'(bus.data_ready), (m_pending != 0) ? 1 : 0);
    chk({tag, "_primed"}, int'(bus.primed), m_primed);
    chk({tag, "_block_done"}, int'(bus.block_done), m_bd);
    chk({tag, "_overflow"}, int'(bus.overflow), m_ovf);
    chk({tag, "_underflow"}, int'(bus.underflow), m_unf);
  endtask

  task automatic step(int se, int dt, int fl, int sm, int rs, int do_check = 0);
    bus.shift_enable = (se != 0);
    bus.data_taken   = (dt != 0);
    bus.flush        = (fl != 0);
    bus.stream_mode  = (sm != 0);
    rst              = (rs != 0);
    @(posedge clk);
    model_edge(se, dt, fl, sm, rs);
    #1;
    if (do_check != 0) check_model("mdl");
  endtask

  task automatic pulses(int n, int sm);
    repeat (n) step(1, 0, 0, sm, 0);
  endtask

  typedef struct {
    int mode;
    int npulse;
    int ntake;
    int exp_pend;
    int exp_ovf;
    int exp_unf;
    int exp_primed;
    int exp_bc;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{0, 128, 0, 1, 0, 0, 1, 0};
    vecs[1]  = '{0, 128, 1, 0, 0, 0, 1, 0};
    vecs[2]  = '{1, 128, 0, 1, 0, 0, 1, 0};
    vecs[3]  = '{1, 112, 0, 0, 0, 0, 0, 112};
    vecs[4]  = '{1, 144, 0, 2, 0, 0, 1, 16};
    vecs[5]  = '{1, 176, 0, 4, 0, 0, 1, 48};
    vecs[6]  = '{1, 192, 0, 4, 1, 0, 1, 64};
    vecs[7]  = '{0, 640, 0, 4, 1, 0, 1, 0};
    vecs[8]  = '{0, 0, 1, 0, 0, 1, 0, 0};
    vecs[9]  = '{1, 176, 2, 2, 0, 0, 1, 48};
    vecs[10] = '{0, 256, 3, 0, 0, 1, 1, 0};

    // Reset state
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_pending", int'(bus.pending), 0);
    chk("rst_ready", int'(bus.data_ready), 0);
    chk("rst_bit_count", int'(bus.bit_count), 0);
    chk("rst_primed", int'(bus.primed), 0);
    chk("rst_flags", int'({bus.overflow, bus.underflow, bus.block_done}), 0);
    step(0, 0, 0, 0, 0);

    // Vector table
    for (int i = 0; i < 11; i++) begin
      step(0, 0, 1, vecs[i].mode, 0);
      pulses(vecs[i].npulse, vecs[i].mode);
      repeat (vecs[i].ntake) step(0, 1, 0, vecs[i].mode, 0);
      chk($sformatf("v%0d_pending", i), int'(bus.pending), vecs[i].exp_pend);
      chk($sformatf("v%0d_ready", i), int'(bus.data_ready), (vecs[i].exp_pend != 0) ? 1 : 0);
      chk($sformatf("v%0d_overflow", i), int'(bus.overflow), vecs[i].exp_ovf);
      chk($sformatf("v%0d_underflow", i), int'(bus.underflow), vecs[i].exp_unf);
      chk($sformatf("v%0d_primed", i), int'(bus.primed), vecs[i].exp_primed);
      chk($sformatf("v%0d_bit_count", i), int'(bus.bit_count), vecs[i].exp_bc);
    end

    // block_done is a single-cycle pulse, primed rises with it
    step(0, 0, 1, 0, 0);
    pulses(127, 0);
    chk("bd_before", int'(bus.block_done), 0);
    chk("bd_primed_before", int'(bus.primed), 0);
    pulses(1, 0);
    chk("bd_pulse", int'(bus.block_done), 1);
    chk("bd_primed", int'(bus.primed), 1);
    chk("bd_pending", int'(bus.pending), 1);
    step(0, 0, 0, 0, 0);
    chk("bd_drop", int'(bus.block_done), 0);
    step(0, 1, 0, 0, 0);
    chk("take_pending", int'(bus.pending), 0);
    chk("take_ready", int'(bus.data_ready), 0);

    // Chunk credit and take in the same cycle cancel
    step(0, 0, 1, 1, 0);
    pulses(159, 1);
    chk("sim_pending_pre", int'(bus.pending), 2);
    step(1, 1, 0, 1, 0);
    chk("sim_pending", int'(bus.pending), 2);
    chk("sim_underflow", int'(bus.underflow), 0);

    // Overflow stays sticky across takes until flush
    step(0, 0, 1, 1, 0);
    pulses(192, 1);
    step(0, 1, 0, 1, 0);
    chk("ovf_take_pending", int'(bus.pending), 3);
    chk("ovf_sticky", int'(bus.overflow), 1);
    step(0, 0, 1, 1, 0);
    chk("ovf_flush", int'(bus.overflow), 0);

    // Flush at bit 70 with a bit present: bit discarded, back to idle
    pulses(198, 1);
    chk("fl_bc_pre", int'(bus.bit_count), 70);
    step(1, 0, 1, 1, 0);
    chk("fl_bc", int'(bus.bit_count), 0);
    chk("fl_primed", int'(bus.primed), 0);
    chk("fl_pending", int'(bus.pending), 0);
    pulses(127, 1);
    chk("fl_no_credit", int'(bus.pending), 0);
    pulses(1, 1);
    chk("fl_credit", int'(bus.pending), 1);

    // Reset mid-stream; mode is relatched on the next first bit
    step(0, 0, 1, 1, 0);
    pulses(160, 1);
    chk("rs_pending_pre", int'(bus.pending), 3);
    step(1, 0, 0, 1, 1);
    chk("rs_pending", int'(bus.pending), 0);
    chk("rs_bc", int'(bus.bit_count), 0);
    chk("rs_primed", int'(bus.primed), 0);
    step(1, 0, 0, 0, 0);
    pulses(143, 1);
    chk("rs_relatch_block", int'(bus.pending), 1);
    chk("rs_relatch_bc", int'(bus.bit_count), 16);

    // Randomized traffic against the model
    step(0, 0, 0, 0, 1, 1);
    for (int c = 0; c < 4000; c++) begin
      int se, dt, fl, sm, rs;
      se = ($urandom_range(99) < 75) ? 1 : 0;
      dt = ($urandom_range(99) < 20) ? 1 : 0;
      fl = ($urandom_range(999) < 4) ? 1 : 0;
      rs = ($urandom_range(999) < 2) ? 1 : 0;
      sm = ($urandom_range(99) < 60) ? 1 : 0;
      step(se, dt, fl, sm, rs, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
